// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg                                                              |
// | Shared types, constants and helpers for the load/store unit.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

    localparam int LSU_DEPTH_WORDS = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_ACC1 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // The illegal size reports 4 so range arithmetic stays well defined.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// +----------------------------------------------------------------------+
// | lsu_if                                                               |
// | Request/response and data_memory bus of the load/store unit.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface lsu_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wd;
    logic            mem_we;
    logic [XLEN-1:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wd, mem_we
    );
endinterface

`default_nettype wire

// File: rtl/lsu_align.sv
// +----------------------------------------------------------------------+
// | lsu_align                                                            |
// | Store byte merge and load extract/extend (combinational).            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  off,
    input  logic        hi_word,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    input  logic [31:0] buf0,
    input  logic [31:0] buf1,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [2:0]  w_nbytes;
    logic [2:0]  w_base;
    logic [31:0] w_raw;

    assign w_nbytes = size_bytes(size);
    assign w_base   = hi_word ? 3'd4 : 3'd0;

    // Lane b takes store byte k; k wraps above 3 for lanes outside the access.
    generate
        for (genvar b = 0; b < 4; b++) begin : g_lane
            logic [2:0] w_k;
            assign w_k = 3'(b) + w_base - {1'b0, off};
            assign merged[8*b +: 8] = (w_k < w_nbytes) ? wdata[8*w_k[1:0] +: 8] : rd[8*b +: 8];
        end
    endgenerate

    assign w_raw = 32'({buf1, buf0} >> {off, 3'b000});

    always_comb begin
        load_data = w_raw;
        case (size)
            SZ_B:    load_data = is_unsigned ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}}, w_raw[7:0]};
            SZ_H:    load_data = is_unsigned ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: load_data = w_raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit                                                      |
// | Byte-addressed load/store front end for a word-indexed data_memory.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = LSU_DEPTH_WORDS,
    parameter int XLEN        = 32
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);

    localparam logic [XLEN:0] c_byte_limit = (XLEN+1)'(DEPTH_WORDS * 4);

    state_e          r_state;
    state_e          w_state_next;
    logic            r_we;
    logic            r_unsigned;
    logic            r_span;
    logic            r_err;
    logic [1:0]      r_size;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_buf0;
    logic [XLEN-1:0] r_buf1;

    logic            w_ready;
    logic            w_accept;
    logic [2:0]      w_nbytes;
    logic [XLEN:0]   w_end;
    logic            w_dec_err;
    logic            w_dec_span;
    logic            w_hi_word;
    logic [XLEN-1:0] w_merged;
    logic [XLEN-1:0] w_load;

    assign w_nbytes   = size_bytes(bus.req_size);
    assign w_end      = {1'b0, bus.req_addr} + (XLEN+1)'(w_nbytes);
    assign w_dec_err  = (bus.req_size == SZ_BAD) || (w_end > c_byte_limit);
    assign w_dec_span = ({1'b0, bus.req_addr[1:0]} + w_nbytes) > 3'd4;
    assign w_ready    = (r_state == ST_IDLE) && !rst;
    assign w_accept   = bus.req_valid && w_ready;
    assign w_hi_word  = (r_state == ST_ACC1);
    assign bus.req_ready = w_ready;

    lsu_align u_align (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .off         (r_off),
        .hi_word     (w_hi_word),
        .wdata       (r_wdata),
        .rd          (bus.mem_rd),
        .buf0        (r_buf0),
        .buf1        (r_buf1),
        .merged      (w_merged),
        .load_data   (w_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_span     <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_off      <= 2'b00;
            r_lo       <= '0;
            r_wdata    <= '0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_unsigned <= bus.req_unsigned;
                r_size     <= bus.req_size;
                r_off      <= bus.req_addr[1:0];
                r_lo       <= bus.req_addr >> 2;
                r_wdata    <= bus.req_wdata;
                r_span     <= w_dec_span;
                r_err      <= w_dec_err;
            end
            if (r_state == ST_ACC0) r_buf0 <= bus.mem_rd;
            if (r_state == ST_ACC1) r_buf1 <= bus.mem_rd;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.mem_addr  = '0;
        bus.mem_wd    = '0;
        bus.mem_we    = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = w_dec_err ? ST_RESP : ST_ACC0;
            end
            ST_ACC0: begin
                bus.mem_addr = r_lo;
                bus.mem_we   = r_we;
                bus.mem_wd   = r_we ? w_merged : '0;
                w_state_next = r_span ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
                bus.mem_addr = r_lo + XLEN'(1);
                bus.mem_we   = r_we;
                bus.mem_wd   = r_we ? w_merged : '0;
                w_state_next = ST_RESP;
            end
            default: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = (r_we || r_err) ? '0 : w_load;
                w_state_next  = ST_IDLE;
            end
        endcase
        // Reset gates every output so an aborted access cannot write or respond.
        if (rst) begin
            w_state_next  = ST_IDLE;
            bus.mem_addr  = '0;
            bus.mem_wd    = '0;
            bus.mem_we    = 1'b0;
            bus.rsp_valid = 1'b0;
            bus.rsp_rdata = '0;
            bus.rsp_err   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit                                                   |
// | Self-checking bench with a byte-level memory reference model.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

    localparam int DEPTH = 32;
    localparam int NBYTES_MEM = DEPTH * 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if bus_if ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    logic [31:0] mem [DEPTH];
    logic [7:0]  ref_mem [NBYTES_MEM];
    int checks = 0;
    int errors = 0;

    assign bus_if.mem_rd = (bus_if.mem_addr < 32'(DEPTH)) ? mem[bus_if.mem_addr[4:0]] : 32'hDEAD_BEEF;
    always @(posedge clk) if (bus_if.mem_we && bus_if.mem_addr < 32'(DEPTH)) mem[bus_if.mem_addr[4:0]] <= bus_if.mem_wd;

    task automatic reload_mem();
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = 32'(k);
            for (int b = 0; b < 4; b++) ref_mem[4*k+b] = 8'(k >> (8*b));
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_err(input logic [1:0] s, input logic [31:0] a);
        return (s == 2'b11) || (longint'(a) + longint'(nb(s)) > longint'(NBYTES_MEM));
    endfunction

    function automatic bit m_span(input logic [1:0] s, input logic [31:0] a);
        return (int'(a % 4) + nb(s)) > 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v = '0;
        int n = nb(s);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
        if (!u && n < 4 && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        for (int i = 0; i < nb(s); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] m_word(input int k);
        return {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
    endfunction

    // Drives one request and observes six cycles after the accept edge.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int nrsp, output logic [31:0] rdata,
                           output logic err, output int nwe, output logic [31:0] wa0, output logic [31:0] wa1);
        int waitc = 0;
        lat = -1; nrsp = 0; rdata = '0; err = 1'b0; nwe = 0; wa0 = '0; wa1 = '0;
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = we; bus_if.req_size = size;
        bus_if.req_unsigned = uns; bus_if.req_addr = addr; bus_if.req_wdata = wdata;
        while (!bus_if.req_ready && waitc < 20) begin @(negedge clk); waitc++; end
        if (!bus_if.req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", bus_if.req_ready);
            bus_if.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus_if.req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus_if.mem_we) begin
                if (nwe == 0) wa0 = bus_if.mem_addr; else wa1 = bus_if.mem_addr;
                nwe++;
            end
            if (bus_if.rsp_valid) begin
                if (lat < 0) begin lat = c; rdata = bus_if.rsp_rdata; err = bus_if.rsp_err; end
                nrsp++;
            end
        end
    endtask

    task automatic test_reset();
        bus_if.req_valid = 0; bus_if.req_we = 0; bus_if.req_size = 0;
        bus_if.req_unsigned = 0; bus_if.req_addr = 0; bus_if.req_wdata = 0;
        rst = 1'b1;
        reload_mem();
        repeat (3) @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus_if.req_ready); end
        checks++; if (bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus_if.rsp_valid); end
        checks++; if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wd} !== 65'd0) begin errors++; $display("FAIL reset_mem_bus: we=%b addr=%h wd=%h expected all 0", bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wd); end
        checks++; if ({bus_if.rsp_err, bus_if.rsp_rdata} !== 33'd0) begin errors++; $display("FAIL reset_rsp: err=%b rdata=%h expected 0", bus_if.rsp_err, bus_if.rsp_rdata); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", bus_if.req_ready); end
    endtask

    task automatic test_aligned_load();
        int lat, nrsp, nwe; logic [31:0] rd, wa0, wa1; logic er;
        run_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, lat, nrsp, rd, er, nwe, wa0, wa1);
        checks++; if (lat !== 2 || nrsp !== 1) begin errors++; $display("FAIL lw_latency: lat=%0d nrsp=%0d expected 2/1", lat, nrsp); end
        checks++; if (rd !== 32'h3) begin errors++; $display("FAIL lw_data: got %h expected 00000003", rd); end
        checks++; if (er !== 1'b0 || nwe !== 0) begin errors++; $display("FAIL lw_side: err=%b nwe=%0d expected 0/0", er, nwe); end
    endtask

    task automatic test_extension();
        int lat, nrsp, nwe; logic [31:0] rd, wa0, wa1; logic er;
        logic [31:0] t_addr [4] = '{32'h08, 32'h08, 32'h0A, 32'h0A};
        logic [1:0]  t_size [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        t_uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_exp  [4] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8070, 32'h00008070};
        run_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h807060F0, lat, nrsp, rd, er, nwe, wa0, wa1);
        m_store(32'h08, 2'b10, 32'h807060F0);
        checks++; if (nwe !== 1 || wa0 !== 32'd2 || mem[2] !== 32'h807060F0) begin errors++; $display("FAIL sw_aligned: nwe=%0d addr=%h word2=%h expected 1/2/807060f0", nwe, wa0, mem[2]); end
        checks++; if (rd !== 32'h0 || lat !== 2) begin errors++; $display("FAIL sw_rsp: rdata=%h lat=%0d expected 0/2", rd, lat); end
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, lat, nrsp, rd, er, nwe, wa0, wa1);
            checks++; if (rd !== t_exp[i]) begin errors++; $display("FAIL extend_%0d: got %h expected %h", i, rd, t_exp[i]); end
        end
    endtask

    task automatic test_subword_store();
        int lat, nrsp, nwe, bad; logic [31:0] rd, wa0, wa1, wdat; logic er;
        reload_mem();
        wdat = ($urandom() & 32'hFFFFFF00) | 32'hAB;
        run_req(1'b1, 2'b00, 1'b0, 32'h05, wdat, lat, nrsp, rd, er, nwe, wa0, wa1);
        m_store(32'h05, 2'b00, wdat);
        checks++; if (nwe !== 1 || wa0 !== 32'd1) begin errors++; $display("FAIL sb_we: nwe=%0d addr=%h expected 1/1", nwe, wa0); end
        checks++; if (mem[1] !== 32'h0000AB01) begin errors++; $display("FAIL sb_word1: got %h expected 0000ab01", mem[1]); end
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== m_word(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL sb_other_words: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_misaligned();
        int lat, nrsp, nwe; logic [31:0] rd, wa0, wa1; logic er;
        reload_mem();
        run_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h11223344, lat, nrsp, rd, er, nwe, wa0, wa1);
        m_store(32'h06, 2'b10, 32'h11223344);
        checks++; if (nwe !== 2 || wa0 !== 32'd1 || wa1 !== 32'd2) begin errors++; $display("FAIL sw_span_we: nwe=%0d a0=%h a1=%h expected 2/1/2", nwe, wa0, wa1); end
        checks++; if (mem[1] !== 32'h33440001 || mem[2] !== 32'h00001122) begin errors++; $display("FAIL sw_span_words: w1=%h w2=%h expected 33440001/00001122", mem[1], mem[2]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL sw_span_lat: got %0d expected 3", lat); end
        run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, nrsp, rd, er, nwe, wa0, wa1);
        checks++; if (rd !== 32'h11223344 || lat !== 3) begin errors++; $display("FAIL lw_span: rdata=%h lat=%0d expected 11223344/3", rd, lat); end
    endtask

    task automatic test_errors();
        int lat, nrsp, nwe, bad; logic [31:0] rd, wa0, wa1; logic er;
        logic        e_we   [3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0]  e_size [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] e_addr [3] = '{32'h7E, 32'h00, 32'h7F};
        for (int i = 0; i < 3; i++) begin
            run_req(e_we[i], e_size[i], 1'b0, e_addr[i], $urandom(), lat, nrsp, rd, er, nwe, wa0, wa1);
            checks++; if (er !== 1'b1 || lat !== 1 || nrsp !== 1) begin errors++; $display("FAIL err_%0d_rsp: err=%b lat=%0d nrsp=%0d expected 1/1/1", i, er, lat, nrsp); end
            checks++; if (rd !== 32'h0 || nwe !== 0) begin errors++; $display("FAIL err_%0d_side: rdata=%h nwe=%0d expected 0/0", i, rd, nwe); end
        end
        run_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, lat, nrsp, rd, er, nwe, wa0, wa1);
        checks++; if (er !== 1'b0 || lat !== 2 || rd !== m_load(32'h7C, 2'b10, 1'b0)) begin errors++; $display("FAIL last_word: err=%b lat=%0d rdata=%h expected 0/2/%h", er, lat, rd, m_load(32'h7C, 2'b10, 1'b0)); end
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== m_word(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL err_no_write: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b;
        int rsp_c [$];
        logic [31:0] rsp_d [$];
        logic [5:0] ready_seen = '0;
        exp_a = m_load(32'h10, 2'b10, 1'b0);
        exp_b = m_load(32'h14, 2'b00, 1'b1);
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_size = 2'b10;
        bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'h10;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin bus_if.req_size = 2'b00; bus_if.req_unsigned = 1'b1; bus_if.req_addr = 32'h14; end
            if (c == 4) bus_if.req_valid = 1'b0;
            if (c <= 6) ready_seen[c-1] = bus_if.req_ready;
            if (bus_if.rsp_valid) begin rsp_c.push_back(c); rsp_d.push_back(bus_if.rsp_rdata); end
        end
        checks++; if (ready_seen[2:0] !== 3'b100) begin errors++; $display("FAIL b2b_ready: got %b expected 100", ready_seen[2:0]); end
        checks++; if (rsp_c.size() !== 2) begin errors++; $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_c.size()); end
        else begin
            checks++; if (rsp_c[0] !== 2 || rsp_c[1] !== 5) begin errors++; $display("FAIL b2b_timing: got %0d,%0d expected 2,5", rsp_c[0], rsp_c[1]); end
            checks++; if (rsp_d[0] !== exp_a || rsp_d[1] !== exp_b) begin errors++; $display("FAIL b2b_data: got %h,%h expected %h,%h", rsp_d[0], rsp_d[1], exp_a, exp_b); end
        end
    endtask

    task automatic test_reset_mid_op();
        reload_mem();
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_size = 2'b10;
        bus_if.req_unsigned = 1'b0; bus_if.req_addr = 32'h06; bus_if.req_wdata = 32'h11223344;
        checks++; if (bus_if.req_ready !== 1'b1) begin errors++; $display("FAIL rmo_ready_pre: got %b expected 1", bus_if.req_ready); end
        @(posedge clk); #1 bus_if.req_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.mem_we !== 1'b1 || bus_if.mem_addr !== 32'd1) begin errors++; $display("FAIL rmo_acc0: we=%b addr=%h expected 1/1", bus_if.mem_we, bus_if.mem_addr); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus_if.mem_we !== 1'b0) begin errors++; $display("FAIL rmo_we_gated: got %b expected 0", bus_if.mem_we); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b0) begin errors++; $display("FAIL rmo_in_reset: rsp_valid=%b ready=%b expected 0/0", bus_if.rsp_valid, bus_if.req_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin errors++; $display("FAIL rmo_after: ready=%b rsp_valid=%b expected 1/0", bus_if.req_ready, bus_if.rsp_valid); end
        ref_mem[6] = 8'h44; ref_mem[7] = 8'h33;
        checks++; if (mem[1] !== m_word(1) || mem[2] !== m_word(2)) begin errors++; $display("FAIL rmo_words: w1=%h w2=%h expected %h/%h", mem[1], mem[2], m_word(1), m_word(2)); end
    endtask

    task automatic test_random();
        int lat, nrsp, nwe, r, exp_lat, exp_nwe, bad; logic [31:0] rd, wa0, wa1, addr, wdat, exp_rd; logic er, we, uns, exp_err;
        logic [1:0] size;
        for (int n = 0; n < 200; n++) begin
            addr = 32'($urandom_range(0, 135));
            r = int'($urandom_range(0, 15));
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            we = 1'($urandom()); uns = 1'($urandom()); wdat = $urandom();
            exp_err = m_err(size, addr);
            exp_lat = exp_err ? 1 : (m_span(size, addr) ? 3 : 2);
            exp_rd  = (we || exp_err) ? 32'h0 : m_load(addr, size, uns);
            exp_nwe = (we && !exp_err) ? (m_span(size, addr) ? 2 : 1) : 0;
            run_req(we, size, uns, addr, wdat, lat, nrsp, rd, er, nwe, wa0, wa1);
            if (we && !exp_err) m_store(addr, size, wdat);
            checks++; if (er !== exp_err) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b addr=%h size=%0d", n, er, exp_err, addr, size); end
            checks++; if (lat !== exp_lat || nrsp !== 1) begin errors++; $display("FAIL rnd_lat[%0d]: lat=%0d nrsp=%0d expected %0d/1", n, lat, nrsp, exp_lat); end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h addr=%h size=%0d uns=%b", n, rd, exp_rd, addr, size, uns); end
            checks++; if (nwe !== exp_nwe || (nwe > 0 && wa0 !== (addr >> 2))) begin errors++; $display("FAIL rnd_we[%0d]: nwe=%0d a0=%h expected %0d/%h", n, nwe, wa0, exp_nwe, addr >> 2); end
        end
        bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== m_word(k)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rnd_memory: %0d words differ, expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_extension();
        test_subword_store();
        test_misaligned();
        test_errors();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data_memory.
- Accepts byte-addressed load/store requests over a valid/ready handshake and turns them into word-indexed data_memory accesses (A, WD, WE, combinational RD).
- data_memory has no byte enables, so sub-word stores are done as read-merge-write in one cycle.
- Misaligned accesses are split into two word accesses. Loads are extracted and sign/zero-extended.

Parameters:
- DEPTH_WORDS, 32, number of 32-bit words in data_memory; legal byte range is 0 .. DEPTH_WORDS*4-1.
- XLEN, 32, data and address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads when 1.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  XLEN  load result; 0 for stores and errors.
- rsp_err  out  1  illegal size or out-of-range access.
- mem_addr  out  XLEN  word index to data_memory A.
- mem_wd  out  XLEN  write data to data_memory WD.
- mem_we  out  1  write enable to data_memory WE.
- mem_rd  in  XLEN  combinational read data from data_memory RD.

Behaviour:
- Reset: clk is the single clock; rst is synchronous and active-high.
  - While rst is high: state <= IDLE; rsp_valid, rsp_err, rsp_rdata, mem_we, mem_wd and mem_addr are 0; req_ready is forced 0.
  - Reset mid-operation aborts the access. A misaligned store aborted after ACC0 leaves the low word written; this is accepted.
- FSM states: IDLE, ACC0, ACC1, RESP.
  - req_ready = (state == IDLE) && !rst.
  - Accept = req_valid && req_ready; the request is latched on accept.
- Decode at accept:
  - nbytes = 1/2/4.
  - lo = addr >> 2; off = addr[1:0]; span = (off + nbytes > 4).
  - err = (size == 11) || (addr + nbytes > DEPTH_WORDS*4).
  - err → next state RESP, with no memory access.
  - Otherwise → ACC0.
- ACC0:
  - mem_addr = lo; mem_rd is captured into buf0.
  - Store: mem_we = 1; mem_wd = mem_rd with bytes off .. min(3, off+nbytes-1) replaced by req_wdata bytes 0.. (little-endian). A full aligned word store writes req_wdata directly.
  - Next state: ACC1 if span, else RESP.
- ACC1:
  - mem_addr = lo + 1; mem_rd is captured into buf1.
  - Store: mem_we = 1; bytes 0 .. off+nbytes-5 are replaced by the remaining req_wdata bytes.
  - Next state: RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - Load rsp_rdata = ({buf1, buf0} >> 8*off), truncated to nbytes, then sign-extended (req_unsigned = 0) or zero-extended.
  - Next state: IDLE.
- Latency (accept edge at T):
  - aligned access: rsp_valid in cycle T+2;
  - spanning access: T+3;
  - error: T+1.
  - Throughput is one request per 3 (aligned) or 4 (spanning) cycles.
- Response interface: no back-pressure; the consumer must take rsp_valid when it is presented.
- Write-enable rules:
  - mem_we is high only in ACC0/ACC1 for stores, at most 2 cycles per request.
  - Never on error; range is checked before any write, so no partial store on wrap past the last word.
- Idle outputs: outside ACC0/ACC1, mem_addr = 0, mem_wd = 0, mem_we = 0.
- Request inputs: ignored while not in IDLE.

Decomposition:
- lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_BAD);
  - FSM state enum;
  - the byte-count function;
  - DEPTH_WORDS default.
- Sub-module lsu_align (combinational): performs the byte merge for stores and the extract/extend for loads. The top level keeps the FSM, request latches and buf0/buf1.

Test Plan:
(data_memory reset leaves word k = k.)
1. Aligned load: LW addr 0x0C accepted at T → rsp_valid in T+2 only, rsp_rdata 0x00000003, rsp_err 0, mem_we never high.
2. Sign/zero extension: SW 0x807060F0 to 0x08; then LB 0x08 → 0xFFFFFFF0; LBU 0x08 → 0x000000F0; LH 0x0A → 0xFFFF8070; LHU 0x0A → 0x00008070.
3. Sub-word store: SB 0xAB to 0x05 → word1 = 0x0000AB01, other words unchanged, mem_we high exactly 1 cycle with mem_addr = 1.
4. Misaligned store: SW 0x11223344 to 0x06 → word1 = 0x33440001, word2 = 0x00001122, mem_we high 2 cycles (mem_addr 1 then 2). Then LW 0x06 → 0x11223344 with rsp at T+3.
5. Error cases, each giving rsp_err 1 at T+1, rsp_rdata 0, no mem_we:
   - LW 0x7E (crosses 0x80);
   - req_size 11 at 0x00;
   - SH 0x7F.
6. Reset mid-operation: assert rst during ACC1 of the misaligned store in scenario 4 → next cycle state IDLE, rsp_valid 0, req_ready 0 while rst is high, 1 in the first cycle after rst drops; word2 unchanged.
